// File: rtl/rx_dfe_if.sv
// rx_dfe_if: sample, coefficient-write and result bundle of the 4-lane
// receive DFE / PAM5 slicer.
//
// Handshake: io_in_valid qualifies io_in_bits_0..3 on the same cycle and the
// sample is always accepted (there is no ready). io_out_valid is high for
// exactly the one cycle after an accepted sample. io_out_sym/err are held
// between valid results. io_coef_wr is a single-cycle strobe.
interface rx_dfe_if;
  logic              io_in_valid;
  logic signed [7:0] io_in_bits_0;
  logic signed [7:0] io_in_bits_1;
  logic signed [7:0] io_in_bits_2;
  logic signed [7:0] io_in_bits_3;
  logic              io_coef_wr;
  logic [1:0]        io_coef_lane;
  logic [2:0]        io_coef_idx;
  logic signed [7:0] io_coef_data;
  logic              io_adapt;
  logic              io_out_valid;
  logic signed [2:0] io_out_sym_0;
  logic signed [2:0] io_out_sym_1;
  logic signed [2:0] io_out_sym_2;
  logic signed [2:0] io_out_sym_3;
  logic signed [7:0] io_out_err_0;
  logic signed [7:0] io_out_err_1;
  logic signed [7:0] io_out_err_2;
  logic signed [7:0] io_out_err_3;

  // Upstream side: drives samples and coefficient writes, reads results.
  modport master (
    output io_in_valid, io_in_bits_0, io_in_bits_1, io_in_bits_2, io_in_bits_3,
    output io_coef_wr, io_coef_lane, io_coef_idx, io_coef_data, io_adapt,
    input  io_out_valid, io_out_sym_0, io_out_sym_1, io_out_sym_2, io_out_sym_3,
    input  io_out_err_0, io_out_err_1, io_out_err_2, io_out_err_3
  );

  // Equalizer side.
  modport slave (
    input  io_in_valid, io_in_bits_0, io_in_bits_1, io_in_bits_2, io_in_bits_3,
    input  io_coef_wr, io_coef_lane, io_coef_idx, io_coef_data, io_adapt,
    output io_out_valid, io_out_sym_0, io_out_sym_1, io_out_sym_2, io_out_sym_3,
    output io_out_err_0, io_out_err_1, io_out_err_2, io_out_err_3
  );
endinterface

// File: rtl/rx_dfe.sv
// rx_dfe: 4-lane decision-feedback equalizer with PAM5 slicer.
// Each lane subtracts sum(c[k]*d[k+1]) from the incoming sample, slices the
// result to -2..+2 and reports the saturated slicer error one cycle later.
// Optional feature: define RX_DFE_LMS_EN to compile in sign-sign LMS
// adaptation of the feedback taps (gated by io_adapt).
module rx_dfe #(
  parameter int NTAPS = 4,  // feedback taps per lane, 1..8
  parameter int LEVEL = 32  // PAM5 level spacing in input LSBs
) (
  input  logic    clock,
  input  logic    reset,    // asynchronous, active-low
  rx_dfe_if.slave bus
);

  localparam int NL = 4;
  localparam logic signed [13:0] LVL    = 14'(LEVEL);
  localparam logic signed [13:0] TH_LO  = 14'(LEVEL / 2);
  localparam logic signed [13:0] TH_HI  = 14'((3 * LEVEL) / 2);

  // hist_q[l][k] holds d[k+1] (k = 0 is the most recent decision).
  logic signed [2:0] hist_q [NL][NTAPS];
  logic signed [2:0] hist_d [NL][NTAPS];
  logic signed [7:0] coef_q [NL][NTAPS];
  logic signed [7:0] coef_d [NL][NTAPS];
  logic signed [2:0] sym_q  [NL];
  logic signed [2:0] sym_d  [NL];
  logic signed [7:0] err_q  [NL];
  logic signed [7:0] err_d  [NL];
  logic              out_valid_q;
  logic              out_valid_d;

  logic signed [7:0]  x      [NL];
  logic signed [13:0] fb     [NL];
  logic signed [13:0] y      [NL];
  logic signed [13:0] e_full [NL];
  logic signed [2:0]  sym_c  [NL];
  logic signed [7:0]  err_c  [NL];

  assign x[0] = bus.io_in_bits_0;
  assign x[1] = bus.io_in_bits_1;
  assign x[2] = bus.io_in_bits_2;
  assign x[3] = bus.io_in_bits_3;

`ifdef RX_DFE_LMS_EN
  // One sign-sign step on a coefficient, held inside [-127, 127].
  function automatic logic signed [7:0] lms_step(input logic signed [7:0] c,
                                                 input logic dec);
    logic signed [8:0] t;
    t = 9'(c);
    t = dec ? (t - 9'sd1) : (t + 9'sd1);
    if (t > 9'sd127)
      t = 9'sd127;
    else if (t < -9'sd127)
      t = -9'sd127;
    return t[7:0];
  endfunction
`else
  // Adaptation is not built; the request input has no effect.
  logic unused_adapt;
  assign unused_adapt = bus.io_adapt;
`endif

  // Feedback sum, equalized sample, slicer decision and saturated error.
  always_comb begin
    for (int l = 0; l < NL; l++) begin
      fb[l] = '0;
      for (int k = 0; k < NTAPS; k++)
        fb[l] = fb[l] + 14'(coef_q[l][k]) * 14'(hist_q[l][k]);
      y[l] = 14'(x[l]) - fb[l];
      if (y[l] >= TH_HI)
        sym_c[l] = 3'sd2;
      else if (y[l] >= TH_LO)
        sym_c[l] = 3'sd1;
      else if (y[l] > -TH_LO)
        sym_c[l] = 3'sd0;
      else if (y[l] > -TH_HI)
        sym_c[l] = 3'b111;
      else
        sym_c[l] = 3'b110;
      e_full[l] = y[l] - 14'(sym_c[l]) * LVL;
      if (e_full[l] > 14'sd127)
        err_c[l] = 8'h7f;
      else if (e_full[l] < -14'sd128)
        err_c[l] = 8'h80;
      else
        err_c[l] = e_full[l][7:0];
    end
  end

  // Next state: history shift and output load on valid, coefficient
  // updates (LMS first, so a same-cycle write overrides it).
  always_comb begin
    hist_d      = hist_q;
    coef_d      = coef_q;
    sym_d       = sym_q;
    err_d       = err_q;
    out_valid_d = bus.io_in_valid;
    if (bus.io_in_valid) begin
      for (int l = 0; l < NL; l++) begin
        sym_d[l]     = sym_c[l];
        err_d[l]     = err_c[l];
        hist_d[l][0] = sym_c[l];
        for (int k = 1; k < NTAPS; k++)
          hist_d[l][k] = hist_q[l][k-1];
      end
    end
`ifdef RX_DFE_LMS_EN
    if (bus.io_in_valid && bus.io_adapt) begin
      for (int l = 0; l < NL; l++) begin
        for (int k = 0; k < NTAPS; k++) begin
          if ((err_c[l] != 8'sd0) && (hist_q[l][k] != 3'sd0))
            coef_d[l][k] = lms_step(coef_q[l][k], err_c[l][7] ^ hist_q[l][k][2]);
        end
      end
    end
`endif
    // Tap indices at or above NTAPS never match and are dropped.
    if (bus.io_coef_wr) begin
      for (int l = 0; l < NL; l++) begin
        for (int k = 0; k < NTAPS; k++) begin
          if ((bus.io_coef_lane == 2'(l)) && (bus.io_coef_idx == 3'(k)))
            coef_d[l][k] = bus.io_coef_data;
        end
      end
    end
  end

  // State registers; reset clears history, taps and outputs at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < NL; l++) begin
        for (int k = 0; k < NTAPS; k++) begin
          hist_q[l][k] <= '0;
          coef_q[l][k] <= '0;
        end
        sym_q[l] <= '0;
        err_q[l] <= '0;
      end
      out_valid_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      coef_q      <= coef_d;
      sym_q       <= sym_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.io_out_valid = out_valid_q;
  assign bus.io_out_sym_0 = sym_q[0];
  assign bus.io_out_sym_1 = sym_q[1];
  assign bus.io_out_sym_2 = sym_q[2];
  assign bus.io_out_sym_3 = sym_q[3];
  assign bus.io_out_err_0 = err_q[0];
  assign bus.io_out_err_1 = err_q[1];
  assign bus.io_out_err_2 = err_q[2];
  assign bus.io_out_err_3 = err_q[3];

endmodule

// File: tb/tb_rx_dfe.sv
// tb_rx_dfe: directed bench for rx_dfe (NTAPS=4, LEVEL=32). Inputs change on
// the falling edge; outputs are read on the falling edge that follows the
// rising edge that loaded them.
module tb_rx_dfe;

  // Clock and reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rx_dfe_if bus ();

  rx_dfe #(.NTAPS(4), .LEVEL(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0][7:0] x;
    logic [3:0][2:0] sym;
    logic [3:0][7:0] err;
  } vec_t;

  vec_t vecs [4];

  // Scoreboard compare
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sym_of(input int l);
    case (l)
      0: return int'($signed(bus.io_out_sym_0));
      1: return int'($signed(bus.io_out_sym_1));
      2: return int'($signed(bus.io_out_sym_2));
      default: return int'($signed(bus.io_out_sym_3));
    endcase
  endfunction

  function automatic int err_of(input int l);
    case (l)
      0: return int'($signed(bus.io_out_err_0));
      1: return int'($signed(bus.io_out_err_1));
      2: return int'($signed(bus.io_out_err_2));
      default: return int'($signed(bus.io_out_err_3));
    endcase
  endfunction

  task automatic chk_lane(input string tag, input int l, input int s, input int e);
    chk($sformatf("%s.sym%0d", tag, l), sym_of(l), s);
    chk($sformatf("%s.err%0d", tag, l), err_of(l), e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s.valid", tag), int'(bus.io_out_valid), 0);
    for (int l = 0; l < 4; l++) chk_lane(tag, l, 0, 0);
  endtask

  // Driver: one falling-edge update of every input
  task automatic drive(input logic v,
                       input logic signed [7:0] x0, input logic signed [7:0] x1,
                       input logic signed [7:0] x2, input logic signed [7:0] x3,
                       input logic wr = 1'b0, input logic [1:0] lane = 2'd0,
                       input logic [2:0] idx = 3'd0,
                       input logic signed [7:0] data = 8'sd0);
    @(negedge clock);
    bus.io_in_valid  = v;
    bus.io_in_bits_0 = x0;
    bus.io_in_bits_1 = x1;
    bus.io_in_bits_2 = x2;
    bus.io_in_bits_3 = x3;
    bus.io_coef_wr   = wr;
    bus.io_coef_lane = lane;
    bus.io_coef_idx  = idx;
    bus.io_coef_data = data;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bus.io_in_valid  = 1'b0;
    bus.io_in_bits_0 = '0;
    bus.io_in_bits_1 = '0;
    bus.io_in_bits_2 = '0;
    bus.io_in_bits_3 = '0;
    bus.io_coef_wr   = 1'b0;
    bus.io_coef_lane = '0;
    bus.io_coef_idx  = '0;
    bus.io_coef_data = '0;
    bus.io_adapt     = 1'b0;

    // lane order in the packed arrays: [0] is lane 0
    vecs[0] = '{x: {8'sd0 - 8'sd33, 8'sd0, 8'sd32, 8'sd64},
                sym: {3'b111, 3'sd0, 3'sd1, 3'sd2},
                err: {8'hff, 8'sd0, 8'sd0, 8'sd0}};
    vecs[1] = '{x: {8'hf1, 8'hf0, 8'sd15, 8'sd16},
                sym: {3'sd0, 3'b111, 3'sd0, 3'sd1},
                err: {8'hf1, 8'sd16, 8'sd15, 8'hf0}};
    vecs[2] = '{x: {8'sd47, 8'h80, 8'sd127, 8'hd0},
                sym: {3'sd1, 3'b110, 3'sd2, 3'b110},
                err: {8'sd15, 8'hc0, 8'sd63, 8'sd16}};
    vecs[3] = '{x: {8'h9c, 8'sd100, 8'hd1, 8'sd48},
                sym: {3'b110, 3'sd2, 3'b111, 3'sd2},
                err: {8'hdc, 8'sd36, 8'hf1, 8'hf0}};

    // Reset held for 5 cycles
    repeat (3) @(negedge clock);
    chk_all_zero("in_reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Slicer table with zero coefficients
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].x[0], vecs[i].x[1], vecs[i].x[2], vecs[i].x[3]);
      drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
      chk($sformatf("vec%0d.valid", i), int'(bus.io_out_valid), 1);
      for (int l = 0; l < 4; l++)
        chk_lane($sformatf("vec%0d", i), l, int'($signed(vecs[i].sym[l])),
                 int'($signed(vecs[i].err[l])));
    end
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    chk("idle.valid", int'(bus.io_out_valid), 0);
    chk_lane("idle_hold", 0, 2, -16);

    // Mid-stream reset: outputs clear without waiting for a clock edge
    drive(1'b1, 8'sd64, 8'sd64, 8'sd64, 8'sd64);
    drive(1'b1, 8'sd100, 8'sd100, 8'sd100, 8'sd100);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    @(negedge clock);
    reset = 1'b1;

    // Feedback path (also shows history was cleared by the reset)
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b1, 2'd0, 3'd0, 8'sd10);
    drive(1'b1, 8'sd64, 8'sd0, 8'sd0, 8'sd0);
    drive(1'b1, 8'sd40, 8'sd0, 8'sd0, 8'sd0);
    chk_lane("fb_first", 0, 2, 0);
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    chk("fb_second.valid", int'(bus.io_out_valid), 1);
    chk_lane("fb_second", 0, 1, -12);
    chk_lane("fb_second", 1, 0, 0);

    // Bubbles: same sequence with three idle cycles between samples
    do_reset();
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b1, 2'd0, 3'd0, 8'sd10);
    drive(1'b1, 8'sd64, 8'sd0, 8'sd0, 8'sd0);
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    chk("bub_first.valid", int'(bus.io_out_valid), 1);
    chk_lane("bub_first", 0, 2, 0);
    for (int g = 0; g < 3; g++) begin
      if (g < 2) drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
      else       drive(1'b1, 8'sd40, 8'sd0, 8'sd0, 8'sd0);
      chk($sformatf("bub_gap%0d.valid", g), int'(bus.io_out_valid), 0);
      chk_lane($sformatf("bub_gap%0d", g), 0, 2, 0);
    end
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    chk("bub_second.valid", int'(bus.io_out_valid), 1);
    chk_lane("bub_second", 0, 1, -12);

    // Write timing, ignored tap index, lane select and a deeper tap
    do_reset();
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b1, 2'd1, 3'd1, 8'hf8);
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b1, 2'd0, 3'd4, 8'sd100);
    drive(1'b1, 8'sd64, 8'sd64, 8'sd0, 8'sd0);
    drive(1'b1, 8'sd40, 8'sd0, 8'sd0, 8'sd0, 1'b1, 2'd0, 3'd0, 8'sd10);
    chk_lane("wt_s1", 0, 2, 0);
    chk_lane("wt_s1", 1, 2, 0);
    drive(1'b1, 8'sd40, 8'sd0, 8'sd0, 8'sd0);
    chk_lane("wt_s2", 0, 1, 8);
    chk_lane("wt_s2", 1, 0, 0);
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    chk_lane("wt_s3", 0, 1, -2);
    chk_lane("wt_s3", 1, 1, -16);

    // Adaptation request: 64, 70, 70 on lane 0
    do_reset();
    bus.io_adapt = 1'b1;
    drive(1'b1, 8'sd64, 8'sd0, 8'sd0, 8'sd0);
    drive(1'b1, 8'sd70, 8'sd0, 8'sd0, 8'sd0);
    chk_lane("adapt_s1", 0, 2, 0);
    drive(1'b1, 8'sd70, 8'sd0, 8'sd0, 8'sd0);
    chk_lane("adapt_s2", 0, 2, 6);
    drive(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
`ifdef RX_DFE_LMS_EN
    chk_lane("adapt_s3", 0, 2, 4);
`else
    chk_lane("adapt_s3", 0, 2, 6);
`endif
    bus.io_adapt = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
